mem_access_unit: RTL and testbench

Sequencing stage between the EX/MEM pipeline register and `data_memory`. Accepts one load or store request at a time over a valid/ready handshake, validates alignment, bounds and funct3 before touching memory, and drives the data memory's address, data, enable and funct3 pins for a programmable number of cycles. It captures load data and returns a single response (data or error) over a second handshake, raising `stall_o` to the hazard unit while busy.

---
 rtl/mem_access_unit_pkg.sv | 36 +++
 rtl/mem_access_unit_checker.sv | 52 +++++
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the memory access sequencing stage: RV32I load/store
// funct3 encodings, the 2-bit FSM state encoding, the default data memory
// size, and a helper that maps a funct3 to its access width in bytes.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

  // RV32I load/store funct3 encodings (stores only use B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Must match the size of the data_memory instance this unit fronts
  localparam int unsigned MEM_SIZE_DEFAULT = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mau_state_e;

  // Access width in bytes; the low two funct3 bits encode the size for both
  // signed and unsigned loads.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_checker.sv
// -----------------------------------------------------------------------------
// mem_req_checker
// Purely combinational legality check for a load/store request, evaluated
// before any memory pin is touched.
// Ports:
//   is_load_i, is_store_i : request kind (exactly one must be set)
//   addr_i                : byte address
//   funct3_i              : RV32I load/store funct3
//   legal_o               : 1 when kind, funct3, alignment and bounds are ok
// -----------------------------------------------------------------------------
module mem_req_checker
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEFAULT
) (
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [31:0] addr_i,
  input  logic [2:0]  funct3_i,
  output logic        legal_o
);

  logic        one_op;
  logic        f3_ok;
  logic        aligned;
  logic        in_bounds;
  logic [32:0] last_byte;

  // The last byte address is formed one bit wider than the address so that a
  // request near 0xFFFF_FFFF cannot wrap around and appear in bounds.
  always_comb begin
    one_op = is_load_i ^ is_store_i;

    if (is_load_i) begin
      f3_ok = funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    end else begin
      f3_ok = funct3_i inside {F3_B, F3_H, F3_W};
    end

    case (funct3_i[1:0])
      2'b01:   aligned = ~addr_i[0];
      2'b10:   aligned = (addr_i[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase

    last_byte = {1'b0, addr_i} + 33'(access_bytes(funct3_i)) - 33'd1;
    in_bounds = (last_byte < 33'(MEM_SIZE));

    legal_o = one_op & f3_ok & aligned & in_bounds;
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Sequencing stage between the EX/MEM register and data_memory. Accepts one
// load/store at a time, rejects illegal requests without touching memory,
// drives the memory pins for WAIT_CYCLES cycles, and returns one response.
// Parameters:
//   WAIT_CYCLES : cycles the memory pins are driven per access (1..15)
//   MEM_SIZE    : data memory size in bytes
// Ports:
//   clk, rst                : clock (rising edge), async active-high reset
//   req_*                   : request handshake and payload
//   resp_*                  : response handshake and payload
//   dm_*                    : data_memory address/data/funct3/enables/rdata
//   stall_o                 : high whenever the unit is not idle
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned MEM_SIZE    = MEM_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_load_i,
  input  logic        req_store_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [4:0]  req_rd_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_is_load_o,
  output logic        resp_err_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  output logic [2:0]  dm_funct3_o,
  output logic        dm_read_en_o,
  output logic        dm_write_en_o,
  input  logic [31:0] dm_rdata_i,
  output logic        stall_o
);

  mau_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        load_q, load_d;
  logic        store_q, store_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_legal;
  logic        in_access;
  logic        in_resp;

  mem_req_checker #(
    .MEM_SIZE (MEM_SIZE)
  ) u_checker (
    .is_load_i  (req_load_i),
    .is_store_i (req_store_i),
    .addr_i     (req_addr_i),
    .funct3_i   (req_funct3_i),
    .legal_o    (req_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      store_q  <= store_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic. The request is latched whether or not it is legal so
  // that rd and the load flag can be echoed in an error response as well.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    store_d  = store_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          load_d   = req_load_i;
          store_d  = req_store_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          funct3_d = req_funct3_i;
          rd_d     = req_rd_i;
          rdata_d  = '0;
          if (req_legal) begin
            state_d = ST_ACCESS;
            cnt_d   = 4'(WAIT_CYCLES - 1);
            err_d   = 1'b0;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          rdata_d = load_q ? dm_rdata_i : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs depend on registered state only, so a reset mid-access drops the
  // memory enables immediately and nothing leaks through from req_valid_i.
  // The write enable is confined to the last ACCESS cycle so a multi-cycle
  // store produces exactly one write pulse.
  always_comb begin
    in_access = (state_q == ST_ACCESS);
    in_resp   = (state_q == ST_RESP);

    req_ready_o    = (state_q == ST_IDLE);
    stall_o        = (state_q != ST_IDLE);

    dm_addr_o      = in_access ? addr_q   : '0;
    dm_wdata_o     = in_access ? wdata_q  : '0;
    dm_funct3_o    = in_access ? funct3_q : '0;
    dm_read_en_o   = in_access & load_q;
    dm_write_en_o  = in_access & store_q & (cnt_q == 4'd0);

    resp_valid_o   = in_resp;
    resp_rdata_o   = in_resp ? rdata_q : '0;
    resp_rd_o      = in_resp ? rd_q    : '0;
    resp_is_load_o = in_resp & load_q;
    resp_err_o     = in_resp & err_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Two instances (WAIT_CYCLES=1 and WAIT_CYCLES=3), each backed by a small
// byte-addressed memory model that returns funct3-extended read data.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_load   [2];
  logic        req_store  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic [4:0]  req_rd     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic [4:0]  resp_rd    [2];
  logic        resp_is_load [2];
  logic        resp_err   [2];
  logic [31:0] dm_addr    [2];
  logic [31:0] dm_wdata   [2];
  logic [2:0]  dm_funct3  [2];
  logic        dm_read_en [2];
  logic        dm_write_en [2];
  logic [31:0] dm_rdata   [2];
  logic        stall      [2];

  int checks = 0;
  int errors = 0;

  // Observations collected by the request driver for the test tasks
  int          obs_lat;
  int          obs_writes;
  int          obs_reads;
  int          obs_en;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic        obs_is_load;
  logic [4:0]  obs_rd;
  logic        obs_ready_in_resp;
  logic        obs_stall_in_resp;

  mem_access_unit #(.WAIT_CYCLES(1), .MEM_SIZE(4096)) u_dut_w1 (
    .clk (clk), .rst (rst[0]),
    .req_valid_i (req_valid[0]), .req_ready_o (req_ready[0]),
    .req_load_i (req_load[0]), .req_store_i (req_store[0]),
    .req_addr_i (req_addr[0]), .req_wdata_i (req_wdata[0]),
    .req_funct3_i (req_funct3[0]), .req_rd_i (req_rd[0]),
    .resp_valid_o (resp_valid[0]), .resp_ready_i (resp_ready[0]),
    .resp_rdata_o (resp_rdata[0]), .resp_rd_o (resp_rd[0]),
    .resp_is_load_o (resp_is_load[0]), .resp_err_o (resp_err[0]),
    .dm_addr_o (dm_addr[0]), .dm_wdata_o (dm_wdata[0]),
    .dm_funct3_o (dm_funct3[0]), .dm_read_en_o (dm_read_en[0]),
    .dm_write_en_o (dm_write_en[0]), .dm_rdata_i (dm_rdata[0]),
    .stall_o (stall[0])
  );

  mem_access_unit #(.WAIT_CYCLES(3), .MEM_SIZE(4096)) u_dut_w3 (
    .clk (clk), .rst (rst[1]),
    .req_valid_i (req_valid[1]), .req_ready_o (req_ready[1]),
    .req_load_i (req_load[1]), .req_store_i (req_store[1]),
    .req_addr_i (req_addr[1]), .req_wdata_i (req_wdata[1]),
    .req_funct3_i (req_funct3[1]), .req_rd_i (req_rd[1]),
    .resp_valid_o (resp_valid[1]), .resp_ready_i (resp_ready[1]),
    .resp_rdata_o (resp_rdata[1]), .resp_rd_o (resp_rd[1]),
    .resp_is_load_o (resp_is_load[1]), .resp_err_o (resp_err[1]),
    .dm_addr_o (dm_addr[1]), .dm_wdata_o (dm_wdata[1]),
    .dm_funct3_o (dm_funct3[1]), .dm_read_en_o (dm_read_en[1]),
    .dm_write_en_o (dm_write_en[1]), .dm_rdata_i (dm_rdata[1]),
    .stall_o (stall[1])
  );

  // Little-endian data memory model per instance: combinational extended
  // read, byte-lane write on the rising edge when the write enable is high.
  for (genvar k = 0; k < 2; k++) begin : g_mem
    bit   [7:0]  mem [4096];
    logic [11:0] a;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] rdata_k;

    assign a  = dm_addr[k][11:0];
    assign b0 = mem[a];
    assign b1 = mem[a + 12'd1];
    assign b2 = mem[a + 12'd2];
    assign b3 = mem[a + 12'd3];

    always_comb begin
      rdata_k = '0;
      case (dm_funct3[k])
        3'b000:  rdata_k = {{24{b0[7]}}, b0};
        3'b001:  rdata_k = {{16{b1[7]}}, b1, b0};
        3'b010:  rdata_k = {b3, b2, b1, b0};
        3'b100:  rdata_k = {24'd0, b0};
        3'b101:  rdata_k = {16'd0, b1, b0};
        default: rdata_k = '0;
      endcase
    end
    assign dm_rdata[k] = rdata_k;

    always @(posedge clk) begin
      if (dm_write_en[k]) begin
        case (dm_funct3[k])
          3'b000: mem[a] = dm_wdata[k][7:0];
          3'b001: begin
            mem[a]         = dm_wdata[k][7:0];
            mem[a + 12'd1] = dm_wdata[k][15:8];
          end
          3'b010: begin
            mem[a]         = dm_wdata[k][7:0];
            mem[a + 12'd1] = dm_wdata[k][15:8];
            mem[a + 12'd2] = dm_wdata[k][23:16];
            mem[a + 12'd3] = dm_wdata[k][31:24];
          end
          default: ;
        endcase
      end
    end
  end

  // Drives one request on instance k starting just after a rising edge with
  // the unit idle, records enables seen and the response, then completes the
  // response handshake and returns just after that edge.
  task automatic do_req(input int k, input logic ld, input logic st,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [4:0] rd);
    bit seen;
    seen       = 0;
    obs_lat    = -1;
    obs_writes = 0;
    obs_reads  = 0;
    obs_en     = 0;
    obs_rdata  = 'x;
    obs_err    = 1'bx;
    obs_is_load = 1'bx;
    obs_rd     = 'x;
    resp_ready[k] = 1'b1;
    req_valid[k]  = 1'b1;
    req_load[k]   = ld;
    req_store[k]  = st;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    req_funct3[k] = f3;
    req_rd[k]     = rd;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_load[k]  = 1'b0;
    req_store[k] = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (dm_write_en[k]) obs_writes++;
      if (dm_read_en[k]) obs_reads++;
      if (dm_write_en[k] || dm_read_en[k]) obs_en++;
      if (resp_valid[k]) begin
        seen        = 1;
        obs_lat     = c;
        obs_rdata   = resp_rdata[k];
        obs_err     = resp_err[k];
        obs_is_load = resp_is_load[k];
        obs_rd      = resp_rd[k];
        obs_ready_in_resp = req_ready[k];
        obs_stall_in_resp = stall[k];
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL resp_timeout dut%0d addr %h got no response exp response", k, addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      req_valid[k] = 1'b0; req_load[k] = 1'b0; req_store[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; req_funct3[k] = '0; req_rd[k] = '0;
      resp_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready dut%0d got %b exp 1", k, req_ready[k]); end
      checks++;
      if (stall[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall dut%0d got %b exp 0", k, stall[k]); end
      checks++;
      if (resp_valid[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid dut%0d got %b exp 0", k, resp_valid[k]); end
      checks++;
      if ({dm_read_en[k], dm_write_en[k]} !== 2'b00) begin errors++; $display("[TB] FAIL reset_enables dut%0d got %b%b exp 00", k, dm_read_en[k], dm_write_en[k]); end
      checks++;
      if (dm_addr[k] !== 32'h0) begin errors++; $display("[TB] FAIL reset_dm_addr dut%0d got %h exp 0", k, dm_addr[k]); end
      checks++;
      if (resp_rdata[k] !== 32'h0) begin errors++; $display("[TB] FAIL reset_resp_rdata dut%0d got %h exp 0", k, resp_rdata[k]); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load_w1();
    logic [31:0] word;
    do_req(0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 5'd0);
    checks++;
    if (obs_writes !== 1) begin errors++; $display("[TB] FAIL sw_write_pulses got %0d exp 1", obs_writes); end
    checks++;
    if (obs_lat !== 1) begin errors++; $display("[TB] FAIL sw_latency got %0d exp 1", obs_lat); end
    checks++;
    if (obs_err !== 1'b0 || obs_is_load !== 1'b0 || obs_rdata !== 32'h0) begin
      errors++; $display("[TB] FAIL sw_resp got err %b is_load %b rdata %h exp 0 0 0", obs_err, obs_is_load, obs_rdata);
    end
    checks++;
    if (obs_ready_in_resp !== 1'b0 || obs_stall_in_resp !== 1'b1) begin
      errors++; $display("[TB] FAIL resp_ready_stall got ready %b stall %b exp 0 1", obs_ready_in_resp, obs_stall_in_resp);
    end
    word = {g_mem[0].mem[12'h103], g_mem[0].mem[12'h102], g_mem[0].mem[12'h101], g_mem[0].mem[12'h100]};
    checks++;
    if (word !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_mem_word got %h exp DEADBEEF", word); end

    do_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 5'd5);
    checks++;
    if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_rdata got %h exp DEADBEEF", obs_rdata); end
    checks++;
    if (obs_lat !== 1) begin errors++; $display("[TB] FAIL lw_latency got %0d exp 1", obs_lat); end
    checks++;
    if (obs_reads !== 1 || obs_writes !== 0) begin errors++; $display("[TB] FAIL lw_enables got reads %0d writes %0d exp 1 0", obs_reads, obs_writes); end
    checks++;
    if (obs_err !== 1'b0 || obs_is_load !== 1'b1 || obs_rd !== 5'd5) begin
      errors++; $display("[TB] FAIL lw_resp got err %b is_load %b rd %0d exp 0 1 5", obs_err, obs_is_load, obs_rd);
    end
    checks++;
    if (req_ready[0] !== 1'b1 || stall[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL after_handshake got ready %b stall %b exp 1 0", req_ready[0], stall[0]);
    end
  endtask

  task automatic test_byte_sign();
    do_req(0, 1'b0, 1'b1, 32'h103, 32'h12345680, 3'b000, 5'd0);
    checks++;
    if (obs_writes !== 1) begin errors++; $display("[TB] FAIL sb_write_pulses got %0d exp 1", obs_writes); end
    checks++;
    if (g_mem[0].mem[12'h103] !== 8'h80 || g_mem[0].mem[12'h102] !== 8'hAD) begin
      errors++; $display("[TB] FAIL sb_mem_bytes got %h %h exp 80 AD", g_mem[0].mem[12'h103], g_mem[0].mem[12'h102]);
    end
    do_req(0, 1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 5'd1);
    checks++;
    if (obs_rdata !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_rdata got %h exp FFFFFF80", obs_rdata); end
    do_req(0, 1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 5'd2);
    checks++;
    if (obs_rdata !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_rdata got %h exp 00000080", obs_rdata); end
    do_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 5'd3);
    checks++;
    if (obs_rdata !== 32'h80ADBEEF) begin errors++; $display("[TB] FAIL lw_after_sb got %h exp 80ADBEEF", obs_rdata); end
  endtask

  task automatic test_errors();
    logic        ld   [9] = '{1, 0, 1, 1, 1, 1, 1, 0, 0};
    logic        st   [9] = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
    logic [31:0] addr [9] = '{32'h102, 32'h101, 32'hFFE, 32'h104, 32'h100,
                              32'h1000, 32'hFFFFFFFC, 32'h100, 32'h100};
    logic [2:0]  f3   [9] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b010,
                              3'b000, 3'b010, 3'b100, 3'b010};
    logic [31:0] word;
    for (int i = 0; i < 9; i++) begin
      do_req(0, ld[i], st[i], addr[i], 32'h55AA55AA, f3[i], 5'd7);
      checks++;
      if (obs_err !== 1'b1) begin errors++; $display("[TB] FAIL err_flag case %0d got %b exp 1", i, obs_err); end
      checks++;
      if (obs_rdata !== 32'h0) begin errors++; $display("[TB] FAIL err_rdata case %0d got %h exp 0", i, obs_rdata); end
      checks++;
      if (obs_en !== 0) begin errors++; $display("[TB] FAIL err_enables case %0d got %0d exp 0", i, obs_en); end
      checks++;
      if (obs_lat !== 0) begin errors++; $display("[TB] FAIL err_latency case %0d got %0d exp 0", i, obs_lat); end
    end
    word = {g_mem[0].mem[12'h103], g_mem[0].mem[12'h102], g_mem[0].mem[12'h101], g_mem[0].mem[12'h100]};
    checks++;
    if (word !== 32'h80ADBEEF) begin errors++; $display("[TB] FAIL err_no_write got %h exp 80ADBEEF", word); end

    // Highest legal word and byte addresses
    do_req(0, 1'b0, 1'b1, 32'hFFC, 32'h01020304, 3'b010, 5'd0);
    checks++;
    if (obs_err !== 1'b0 || obs_writes !== 1) begin errors++; $display("[TB] FAIL sw_top_legal got err %b writes %0d exp 0 1", obs_err, obs_writes); end
    do_req(0, 1'b1, 1'b0, 32'hFFF, 32'h0, 3'b100, 5'd4);
    checks++;
    if (obs_err !== 1'b0 || obs_rdata !== 32'h00000001) begin errors++; $display("[TB] FAIL lbu_top_legal got err %b rdata %h exp 0 00000001", obs_err, obs_rdata); end
  endtask

  task automatic test_wait3();
    do_req(1, 1'b0, 1'b1, 32'h200, 32'hABCD7FFF, 3'b001, 5'd0);
    checks++;
    if (obs_writes !== 1) begin errors++; $display("[TB] FAIL sh_w3_write_pulses got %0d exp 1", obs_writes); end
    checks++;
    if (obs_lat !== 3) begin errors++; $display("[TB] FAIL sh_w3_latency got %0d exp 3", obs_lat); end
    do_req(1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b001, 5'd9);
    checks++;
    if (obs_reads !== 3) begin errors++; $display("[TB] FAIL lh_w3_read_cycles got %0d exp 3", obs_reads); end
    checks++;
    if (obs_lat !== 3) begin errors++; $display("[TB] FAIL lh_w3_latency got %0d exp 3", obs_lat); end
    checks++;
    if (obs_rdata !== 32'h00007FFF || obs_rd !== 5'd9) begin errors++; $display("[TB] FAIL lh_w3_resp got %h rd %0d exp 00007FFF 9", obs_rdata, obs_rd); end
    do_req(1, 1'b0, 1'b1, 32'h202, 32'h00008001, 3'b001, 5'd0);
    do_req(1, 1'b1, 1'b0, 32'h202, 32'h0, 3'b001, 5'd10);
    checks++;
    if (obs_rdata !== 32'hFFFF8001) begin errors++; $display("[TB] FAIL lh_sign_w3 got %h exp FFFF8001", obs_rdata); end
  endtask

  task automatic test_resp_hold();
    bit seen;
    seen = 0;
    resp_ready[1] = 1'b0;
    req_valid[1]  = 1'b1;
    req_load[1]   = 1'b1;
    req_store[1]  = 1'b0;
    req_addr[1]   = 32'h200;
    req_funct3[1] = 3'b010;
    req_rd[1]     = 5'd3;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    req_load[1]  = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (resp_valid[1]) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL hold_resp_timeout got no response exp response"); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid[1] !== 1'b1 || resp_rdata[1] !== 32'h80017FFF || resp_rd[1] !== 5'd3) begin
        errors++; $display("[TB] FAIL hold_payload cycle %0d got valid %b rdata %h rd %0d exp 1 80017FFF 3", c, resp_valid[1], resp_rdata[1], resp_rd[1]);
      end
      checks++;
      if (req_ready[1] !== 1'b0 || stall[1] !== 1'b1) begin
        errors++; $display("[TB] FAIL hold_ready_stall cycle %0d got ready %b stall %b exp 0 1", c, req_ready[1], stall[1]);
      end
    end
    resp_ready[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1 || stall[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_release got valid %b ready %b stall %b exp 0 1 0", resp_valid[1], req_ready[1], stall[1]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_access();
    int          writes;
    int          resps;
    logic [31:0] word;
    writes = 0;
    resps  = 0;
    req_valid[1]  = 1'b1;
    req_load[1]   = 1'b0;
    req_store[1]  = 1'b1;
    req_addr[1]   = 32'h300;
    req_wdata[1]  = 32'hCAFEF00D;
    req_funct3[1] = 3'b010;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    req_store[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (stall[1] !== 1'b1 || dm_addr[1] !== 32'h300) begin
      errors++; $display("[TB] FAIL mid_access_state got stall %b addr %h exp 1 00000300", stall[1], dm_addr[1]);
    end
    #2;
    rst[1] = 1'b1;
    #1;
    checks++;
    if (dm_write_en[1] !== 1'b0 || dm_addr[1] !== 32'h0) begin
      errors++; $display("[TB] FAIL async_reset_pins got we %b addr %h exp 0 0", dm_write_en[1], dm_addr[1]);
    end
    checks++;
    if (req_ready[1] !== 1'b1 || stall[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset_ready got ready %b stall %b exp 1 0", req_ready[1], stall[1]);
    end
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dm_write_en[1]) writes++;
      if (resp_valid[1]) resps++;
    end
    checks++;
    if (writes !== 0 || resps !== 0) begin errors++; $display("[TB] FAIL reset_discard got writes %0d resps %0d exp 0 0", writes, resps); end
    word = {g_mem[1].mem[12'h303], g_mem[1].mem[12'h302], g_mem[1].mem[12'h301], g_mem[1].mem[12'h300]};
    checks++;
    if (word !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_untouched got %h exp 0", word); end
    @(posedge clk);
    #1;
    do_req(1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b010, 5'd6);
    checks++;
    if (obs_rdata !== 32'h80017FFF || obs_lat !== 3) begin errors++; $display("[TB] FAIL post_reset_load got %h lat %0d exp 80017FFF 3", obs_rdata, obs_lat); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish exp finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_store_load_w1();
    test_byte_sign();
    test_errors();
    test_wait3();
    test_resp_hold();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
